div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_pkg.sv | 44 ++++
 rtl/div_round.sv | 92 +++++++++
 rtl/div_iter.sv | 173 +++++++++++++++++
 tb/tb_div_iter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM states,
// rounding-mode encodings and helpers that build canonical special values.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RUP = 2'b10,
    RND_RDN = 2'b11
  } rnd_mode_e;

  localparam int DIV_MAX_W = 64;

  // Helpers return a wide vector; callers truncate to their own format width.
  function automatic logic [DIV_MAX_W-1:0] div_inf(input logic sign, input int expo_w,
                                                    input int mant_w);
    logic [DIV_MAX_W-1:0] ones;
    ones = (DIV_MAX_W'(1) << expo_w) - DIV_MAX_W'(1);
    return (ones << mant_w) | (DIV_MAX_W'(sign) << (expo_w + mant_w));
  endfunction

  function automatic logic [DIV_MAX_W-1:0] div_max(input logic sign, input int expo_w,
                                                    input int mant_w);
    logic [DIV_MAX_W-1:0] e_field;
    logic [DIV_MAX_W-1:0] m_field;
    e_field = ((DIV_MAX_W'(1) << expo_w) - DIV_MAX_W'(2)) << mant_w;
    m_field = (DIV_MAX_W'(1) << mant_w) - DIV_MAX_W'(1);
    return e_field | m_field | (DIV_MAX_W'(sign) << (expo_w + mant_w));
  endfunction

  function automatic logic [DIV_MAX_W-1:0] div_qnan(input int expo_w, input int mant_w);
    logic [DIV_MAX_W-1:0] ones;
    ones = (DIV_MAX_W'(1) << expo_w) - DIV_MAX_W'(1);
    return (ones << mant_w) | (DIV_MAX_W'(1) << (mant_w - 1));
  endfunction

endpackage

// File: rtl/div_round.sv
// Combinational normalise-and-round stage: takes a raw quotient/product
// significand in [0.5, 2) with its exponent and produces the packed result.
module div_round
  import div_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                             sign,
  input  logic signed [EXPO_W+1:0]         exp_in,
  input  logic [MANT_W+2:0]                quo,
  input  logic                             rem_nz,
  input  logic [1:0]                       rnd,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0]  res
);

  localparam int W    = SIGN_W + EXPO_W + MANT_W;
  localparam int N    = MANT_W + 3;
  localparam int EW   = EXPO_W + 2;
  localparam int EMAX = 2**EXPO_W - 1;

  logic [MANT_W:0]        sig;
  logic                   guard;
  logic                   sticky;
  logic                   inc;
  logic                   ovf_inf;
  logic                   ovf;
  logic                   unf;
  logic [MANT_W+1:0]      sum;
  logic [MANT_W-1:0]      frac;
  logic signed [EW-1:0]   exp_n;
  logic signed [EW-1:0]   exp_f;

  always_comb begin
    sig     = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    inc     = 1'b0;
    ovf_inf = 1'b0;
    exp_n   = exp_in;
    exp_f   = exp_in;
    frac    = '0;
    res     = '0;

    // A quotient below one carries its leading bit one place lower.
    if (quo[N-1]) begin
      sig    = quo[N-1 -: MANT_W+1];
      guard  = quo[1];
      sticky = quo[0] | rem_nz;
      exp_n  = exp_in;
    end else begin
      sig    = quo[N-2 -: MANT_W+1];
      guard  = quo[0];
      sticky = rem_nz;
      exp_n  = exp_in - EW'(1);
    end

    case (rnd)
      RND_RNE: inc = guard & (sticky | sig[0]);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = ~sign & (guard | sticky);
      default: inc = sign & (guard | sticky);
    endcase

    sum = {1'b0, sig} + (MANT_W+2)'(inc);
    if (sum[MANT_W+1]) begin
      frac  = sum[MANT_W:1];
      exp_f = exp_n + EW'(1);
    end else begin
      frac  = sum[MANT_W-1:0];
      exp_f = exp_n;
    end

    ovf_inf = (rnd == RND_RNE) | ((rnd == RND_RUP) & ~sign) | ((rnd == RND_RDN) & sign);
    ovf     = ~exp_f[EW-1] && (exp_f[EW-2:0] >= (EW-1)'(EMAX));
    unf     = exp_f[EW-1] || (exp_f == '0);

    if (unf) begin
      res        = '0;
      res[W-1]   = sign;
    end else if (ovf) begin
      res = ovf_inf ? W'(div_inf(sign, EXPO_W, MANT_W)) : W'(div_max(sign, EXPO_W, MANT_W));
    end else begin
      res                   = '0;
      res[W-1]              = sign;
      res[MANT_W +: EXPO_W] = exp_f[EXPO_W-1:0];
      res[MANT_W-1:0]       = frac;
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative IEEE-754 style divider: radix-2 non-restoring significand division,
// one quotient bit per cycle, followed by a single rounding cycle.
module div_iter
  import div_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  a,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  b,
  input  logic [1:0]                       rnd,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0]  res,
  output logic                             flag_nv,
  output logic                             flag_dz,
  output div_state_e                       dbg_state
);

  localparam int W    = SIGN_W + EXPO_W + MANT_W;
  localparam int N    = MANT_W + 3;
  localparam int PW   = MANT_W + 4;
  localparam int EW   = EXPO_W + 2;
  localparam int CW   = $clog2(N + 1);
  localparam int BIAS = 2**(EXPO_W-1) - 1;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid,
  // payload and flags stay stable until accepted, ready never waits on valid.

  div_state_e            state_q, state_d;
  logic [W-1:0]          a_q, b_q;
  logic [1:0]            rnd_q;
  logic [CW-1:0]         cnt_q;
  logic signed [PW-1:0]  p_q;
  logic [N-1:0]          quo_q;
  logic [W-1:0]          res_q;
  logic                  nv_q, dz_q;

  logic                  accept;
  logic                  is_special;
  logic [W-1:0]          spec_res;
  logic                  spec_nv, spec_dz;
  logic [EXPO_W-1:0]     ea_in, eb_in;
  logic                  a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, s_in;

  assign accept    = in_valid && (state_q == IDLE);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign flag_nv   = nv_q;
  assign flag_dz   = dz_q;
  assign dbg_state = state_q;

  assign ea_in  = a[MANT_W +: EXPO_W];
  assign eb_in  = b[MANT_W +: EXPO_W];
  assign a_nan  = (&ea_in) & (|a[MANT_W-1:0]);
  assign a_inf  = (&ea_in) & ~(|a[MANT_W-1:0]);
  assign a_zero = (ea_in == '0);
  assign b_nan  = (&eb_in) & (|b[MANT_W-1:0]);
  assign b_inf  = (&eb_in) & ~(|b[MANT_W-1:0]);
  assign b_zero = (eb_in == '0);
  assign s_in   = a[W-1] ^ b[W-1];

  // Subnormal operands have a zero exponent and so fall into the zero cases.
  always_comb begin
    spec_res   = '0;
    spec_nv    = 1'b0;
    spec_dz    = 1'b0;
    is_special = 1'b1;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_res = W'(div_qnan(EXPO_W, MANT_W));
      spec_nv  = 1'b1;
    end else if (a_inf) begin
      spec_res = W'(div_inf(s_in, EXPO_W, MANT_W));
    end else if (b_zero) begin
      spec_res = W'(div_inf(s_in, EXPO_W, MANT_W));
      spec_dz  = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res[W-1] = s_in;
    end else begin
      is_special = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_special ? DONE : CALC;
      CALC:    if (cnt_q == CW'(N - 1)) state_d = RND;
      RND:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic signed [PW-1:0]  d_ext, p_cur, t_step, t_last, rem;
  logic signed [EW-1:0]  exp_raw;
  logic                  rem_nz;
  logic                  sign_q;
  logic [W-1:0]          rnd_res;

  // The first step divides the dividend itself; later steps use the doubled
  // partial remainder.
  assign d_ext  = {3'b000, 1'b1, b_q[MANT_W-1:0]};
  assign p_cur  = (cnt_q == '0) ? {3'b000, 1'b1, a_q[MANT_W-1:0]} : p_q;
  assign t_step = p_cur[PW-1] ? p_cur + d_ext : p_cur - d_ext;

  // p_q holds twice the last remainder; a negative one is corrected by +D.
  assign t_last = p_q >>> 1;
  assign rem    = quo_q[0] ? t_last : t_last + d_ext;
  assign rem_nz = |rem;

  assign sign_q  = a_q[W-1] ^ b_q[W-1];
  assign exp_raw = signed'({2'b00, a_q[MANT_W +: EXPO_W]}) - signed'({2'b00, b_q[MANT_W +: EXPO_W]})
                 + EW'(BIAS);

  div_round #(
    .SIGN_W (SIGN_W),
    .EXPO_W (EXPO_W),
    .MANT_W (MANT_W)
  ) u_round (
    .sign   (sign_q),
    .exp_in (exp_raw),
    .quo    (quo_q),
    .rem_nz (rem_nz),
    .rnd    (rnd_q),
    .res    (rnd_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      rnd_q <= '0;
      cnt_q <= '0;
      p_q   <= '0;
      quo_q <= '0;
      res_q <= '0;
      nv_q  <= 1'b0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      rnd_q <= rnd;
      cnt_q <= '0;
      quo_q <= '0;
      if (is_special) begin
        res_q <= spec_res;
        nv_q  <= spec_nv;
        dz_q  <= spec_dz;
      end
    end else if (state_q == CALC) begin
      p_q   <= {t_step[PW-2:0], 1'b0};
      quo_q <= {quo_q[N-2:0], ~t_step[PW-1]};
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == RND) begin
      res_q <= rnd_res;
      nv_q  <= 1'b0;
      dz_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter in single precision: hand-computed quotients,
// special cases, overflow/underflow, backpressure and reset abort.
module tb_div_iter;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  rnd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        flag_nv;
  logic        flag_dz;
  div_state_e  dbg_state;

  int pass_cnt;
  int total_cnt;

  div_iter #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flag_nv   (flag_nv),
    .flag_dz   (flag_dz),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  // driver: one full operation including the consuming handshake
  task automatic do_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic [1:0] r_v,
                       output logic [31:0] r_res, output logic [1:0] r_flags, output int r_lat);
    int wait_cnt;
    @(negedge clk);
    a = a_v;
    b = b_v;
    rnd = r_v;
    in_valid = 1'b1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    r_lat = 0;
    while (!out_valid && r_lat < 100) begin
      @(posedge clk);
      #1;
      r_lat++;
    end
    r_res = res;
    r_flags = {flag_nv, flag_dz};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({out_valid, flag_nv, flag_dz} !== 3'b000) $display("FAIL reset_ctrl got=%b exp=000", {out_valid, flag_nv, flag_dz});
    else pass_cnt++;
    total_cnt++;
    if (res !== 32'h0) $display("FAIL reset_res got=%h exp=00000000", res);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || dbg_state !== IDLE) $display("FAIL reset_ready got=%b/%0d exp=1/IDLE", in_ready, dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] r;
    logic [1:0]  f;
    int          lat;
    do_op(32'h40C00000, 32'h40000000, 2'b00, r, f, lat);
    total_cnt++;
    if (r !== 32'h40400000) $display("FAIL basic_res got=%h exp=40400000", r);
    else pass_cnt++;
    total_cnt++;
    if (f !== 2'b00) $display("FAIL basic_flags got=%b exp=00", f);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 27) $display("FAIL basic_latency got=%0d exp=27", lat);
    else pass_cnt++;
  endtask

  task automatic test_rounding();
    logic [31:0] va [8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                            32'hBF800000, 32'hBF800000, 32'h3FC00000, 32'hBF800000};
    logic [31:0] vb [8] = '{32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000,
                            32'h40400000, 32'h40400000, 32'h3FC00000, 32'h40400000};
    logic [1:0]  vr [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [31:0] ve [8] = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'h3EAAAAAA,
                            32'hBEAAAAAB, 32'hBEAAAAAA, 32'h3F800000, 32'hBEAAAAAB};
    logic [31:0] r;
    logic [1:0]  f;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vr[i], r, f, lat);
      total_cnt++;
      if (r !== ve[i] || f !== 2'b00) $display("FAIL round_%0d got=%h/%b exp=%h/00", i, r, f, ve[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_special();
    logic [31:0] va [7] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'hBF800000,
                            32'h7FC00001, 32'hBF800000, 32'h7F800000};
    logic [31:0] vb [7] = '{32'h00000000, 32'h00000000, 32'h40000000, 32'h7F800000,
                            32'h3F800000, 32'h00000000, 32'hFF800000};
    logic [31:0] ve [7] = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h80000000,
                            32'h7FC00000, 32'hFF800000, 32'h7FC00000};
    logic [1:0]  vf [7] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
    logic [31:0] r;
    logic [1:0]  f;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], 2'b00, r, f, lat);
      total_cnt++;
      if (r !== ve[i] || f !== vf[i]) $display("FAIL special_%0d got=%h/%b exp=%h/%b", i, r, f, ve[i], vf[i]);
      else pass_cnt++;
      total_cnt++;
      if (lat !== 0) $display("FAIL special_lat_%0d got=%0d exp=0", i, lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_range();
    logic [31:0] va [6] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF,
                            32'h00800000, 32'h80800000};
    logic [31:0] vb [6] = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                            32'h40000000, 32'h40000000};
    logic [1:0]  vr [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [31:0] ve [6] = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F7FFFFF,
                            32'h00000000, 32'h80000000};
    logic [31:0] r;
    logic [1:0]  f;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vr[i], r, f, lat);
      total_cnt++;
      if (r !== ve[i]) $display("FAIL range_%0d got=%h exp=%h", i, r, ve[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int wait_cnt;
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    rnd = 2'b00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 32'h3F800000;
    b = 32'h40400000;
    rnd = 2'b01;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 100) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    total_cnt++;
    if (res !== 32'h40400000 || wait_cnt !== 27) $display("FAIL bp_first got=%h/%0d exp=40400000/27", res, wait_cnt);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      @(posedge clk);
      #1;
      total_cnt++;
      if ({out_valid, in_ready, flag_nv, flag_dz} !== 4'b1000 || res !== 32'h40400000)
        $display("FAIL bp_hold_%0d got=%b/%h exp=1000/40400000", i, {out_valid, in_ready, flag_nv, flag_dz}, res);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] r;
    logic [1:0]  f;
    int          lat;
    int          seen;
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40400000;
    rnd = 2'b00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++;
    if (dbg_state !== CALC) $display("FAIL abort_in_calc got=%0d exp=CALC", dbg_state);
    else pass_cnt++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 32'h0)
      $display("FAIL abort_reset got=%b%b/%h exp=01/00000000", out_valid, in_ready, res);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    total_cnt++;
    if (seen !== 0 || in_ready !== 1'b1) $display("FAIL abort_no_result got=%0d/%b exp=0/1", seen, in_ready);
    else pass_cnt++;
    do_op(32'h40C00000, 32'h40000000, 2'b00, r, f, lat);
    total_cnt++;
    if (r !== 32'h40400000 || f !== 2'b00 || lat !== 27)
      $display("FAIL abort_next got=%h/%b/%0d exp=40400000/00/27", r, f, lat);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    rnd = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
